// File: rtl/ctrl_mc.sv
// ---------------------------------------------------------------------------
// ctrl_mc -- multi-cycle instruction control FSM
//
// Accepts one instruction per instr_valid/instr_ready handshake and sequences
// it through DECODE / EXEC / MEM / COP_WAIT / WB, waiting on data memory
// (mem_ready) and the custom coprocessor (cop_done). Illegal encodings and
// coprocessor timeouts park the FSM in TRAP until trap_clr.
//
// All outputs are registered: the next-state logic also decodes the outputs
// that belong to the *next* state, so each output is valid for exactly the
// cycle the FSM spends in that state. The store retire pulse is produced on
// the edge that samples mem_ready high, so it shows up in the first IDLE
// cycle after the store's last MEM cycle.
//
// Optional feature macro: CTRL_PERF_EN (performance counters). When it is
// undefined the perf_* ports exist but are tied to zero.
//
// Ports:
//   clk, rst_n                      clock (rising edge), async active-low reset
//   instr_valid / instr_ready       instruction handshake (ready only in IDLE)
//   opcode, funct3, funct7          instruction fields, sampled on accept
//   mem_ready, cop_done, trap_clr   memory done, coprocessor done, leave TRAP
//   reg_write, mem_to_reg,
//   mem_read, mem_write             datapath strobes
//   alu_src                         2'b00 register, 2'b10 immediate
//   pc_src, pc_write                branch select, 1-cycle retire pulse
//   alu_ctrl                        ALU operation code (zero-extended)
//   custom_en, cop_start, cop_op    coprocessor enable, start pulse, funct3
//   trap, trap_cause                trap flag, 2'b01 illegal / 2'b10 timeout
//   perf_retired, perf_stall        saturating performance counters
// ---------------------------------------------------------------------------
module ctrl_mc #(
    parameter int ALU_CTRL_W  = 4,
    parameter int NUM_COP_OPS = 2,
    parameter int COP_TIMEOUT = 64,
    parameter int PERF_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    input  logic [6:0]            opcode,
    input  logic [2:0]            funct3,
    input  logic [6:0]            funct7,
    input  logic                  mem_ready,
    input  logic                  cop_done,
    input  logic                  trap_clr,
    output logic                  reg_write,
    output logic                  mem_to_reg,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [1:0]            alu_src,
    output logic                  pc_src,
    output logic                  pc_write,
    output logic [ALU_CTRL_W-1:0] alu_ctrl,
    output logic                  custom_en,
    output logic                  cop_start,
    output logic [2:0]            cop_op,
    output logic                  trap,
    output logic [1:0]            trap_cause,
    output logic [PERF_W-1:0]     perf_retired,
    output logic [PERF_W-1:0]     perf_stall
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_CUSTOM = 7'b0001011;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    // Counter just wide enough to reach COP_TIMEOUT; it never counts past it.
    localparam int CNT_W = (COP_TIMEOUT > 0) ? $clog2(COP_TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_DECODE   = 3'd1,
        S_EXEC     = 3'd2,
        S_MEM      = 3'd3,
        S_COP_WAIT = 3'd4,
        S_WB       = 3'd5,
        S_TRAP     = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        C_R       = 3'd0,
        C_LOAD    = 3'd1,
        C_STORE   = 3'd2,
        C_BRANCH  = 3'd3,
        C_CUSTOM  = 3'd4,
        C_ILLEGAL = 3'd5
    } cls_t;

    // Instruction class of an opcode/funct3 pair; anything unlisted is illegal.
    function automatic cls_t classify(input logic [6:0] op, input logic [2:0] f3);
        cls_t c;
        c = C_ILLEGAL;
        case (op)
            OP_R: begin
                case (f3)
                    3'b000, 3'b111, 3'b110, 3'b100, 3'b001, 3'b101: c = C_R;
                    default: c = C_ILLEGAL;
                endcase
            end
            OP_LOAD:  c = C_LOAD;
            OP_STORE: c = C_STORE;
            OP_BRANCH: begin
                case (f3)
                    3'b000, 3'b001, 3'b100, 3'b101: c = C_BRANCH;
                    default: c = C_ILLEGAL;
                endcase
            end
            OP_CUSTOM: begin
                if ({29'd0, f3} < 32'(NUM_COP_OPS)) begin
                    c = C_CUSTOM;
                end else begin
                    c = C_ILLEGAL;
                end
            end
            default: c = C_ILLEGAL;
        endcase
        return c;
    endfunction

    // ALU operation code for a legal instruction (loads/stores use ADD).
    function automatic logic [3:0] alu_code(input cls_t c, input logic [2:0] f3, input logic f7_5);
        logic [3:0] a;
        a = 4'd0;
        case (c)
            C_R: begin
                case (f3)
                    3'b000:  a = f7_5 ? 4'd1 : 4'd0;
                    3'b111:  a = 4'd2;
                    3'b110:  a = 4'd3;
                    3'b100:  a = 4'd8;
                    3'b001:  a = 4'd9;
                    3'b101:  a = 4'd10;
                    default: a = 4'd0;
                endcase
            end
            C_BRANCH: begin
                case (f3)
                    3'b000:  a = 4'd4;
                    3'b001:  a = 4'd5;
                    3'b100:  a = 4'd11;
                    3'b101:  a = 4'd12;
                    default: a = 4'd0;
                endcase
            end
            C_CUSTOM: begin
                case (f3)
                    3'b000:  a = 4'd6;
                    3'b001:  a = 4'd7;
                    default: a = 4'd13;
                endcase
            end
            default: a = 4'd0;
        endcase
        return a;
    endfunction

    state_t             state_r, state_nx;
    logic [6:0]         op_r;
    logic [2:0]         f3_r;
    logic               f7_5_r;
    logic [CNT_W-1:0]   cop_cnt_r;
    logic [1:0]         trap_cause_r, trap_cause_nx;
    logic [2:0]         cop_op_r;
    cls_t               cls_s;
    logic [3:0]         code_s;
    logic               timeout_s;
    logic               accept_s;

    // Only funct7[5] (SUB) influences decoding.
    logic unused_f7_s;
    assign unused_f7_s = ^{funct7[6], funct7[4:0]};

    logic                  instr_ready_r, instr_ready_nx;
    logic                  reg_write_r, reg_write_nx;
    logic                  mem_to_reg_r, mem_to_reg_nx;
    logic                  mem_read_r, mem_read_nx;
    logic                  mem_write_r, mem_write_nx;
    logic [1:0]            alu_src_r, alu_src_nx;
    logic                  pc_src_r, pc_src_nx;
    logic                  pc_write_r, pc_write_nx;
    logic [ALU_CTRL_W-1:0] alu_ctrl_r, alu_ctrl_nx;
    logic                  custom_en_r, custom_en_nx;
    logic                  cop_start_r, cop_start_nx;
    logic                  trap_r, trap_nx;

    assign accept_s = (state_r == S_IDLE) && instr_valid;
    assign cls_s    = classify(op_r, f3_r);
    assign code_s   = alu_code(cls_s, f3_r, f7_5_r);

    // Coprocessor timeout: fires on the COP_TIMEOUT-th wait cycle unless done arrives.
    always_comb begin
        timeout_s = 1'b0;
        if ((COP_TIMEOUT > 0) && (state_r == S_COP_WAIT) && !cop_done) begin
            timeout_s = (cop_cnt_r == CNT_W'(COP_TIMEOUT));
        end else begin
            timeout_s = 1'b0;
        end
    end

    // Next-state and trap-cause logic.
    always_comb begin
        state_nx      = state_r;
        trap_cause_nx = trap_cause_r;
        case (state_r)
            S_IDLE: begin
                if (instr_valid) begin
                    state_nx = S_DECODE;
                end else begin
                    state_nx = S_IDLE;
                end
            end
            S_DECODE: begin
                case (cls_s)
                    C_R, C_LOAD, C_STORE, C_BRANCH: state_nx = S_EXEC;
                    C_CUSTOM: state_nx = S_COP_WAIT;
                    default: begin
                        state_nx      = S_TRAP;
                        trap_cause_nx = CAUSE_ILLEGAL;
                    end
                endcase
            end
            S_EXEC: begin
                case (cls_s)
                    C_R:              state_nx = S_WB;
                    C_LOAD, C_STORE:  state_nx = S_MEM;
                    default:          state_nx = S_IDLE;
                endcase
            end
            S_MEM: begin
                if (!mem_ready) begin
                    state_nx = S_MEM;
                end else if (cls_s == C_LOAD) begin
                    state_nx = S_WB;
                end else begin
                    state_nx = S_IDLE;
                end
            end
            S_COP_WAIT: begin
                if (cop_done) begin
                    state_nx = S_WB;
                end else if (timeout_s) begin
                    state_nx      = S_TRAP;
                    trap_cause_nx = CAUSE_TIMEOUT;
                end else begin
                    state_nx = S_COP_WAIT;
                end
            end
            S_WB: state_nx = S_IDLE;
            S_TRAP: begin
                if (trap_clr) begin
                    state_nx      = S_IDLE;
                    trap_cause_nx = CAUSE_NONE;
                end else begin
                    state_nx = S_TRAP;
                end
            end
            default: begin
                state_nx      = S_IDLE;
                trap_cause_nx = CAUSE_NONE;
            end
        endcase
    end

    // Output values for the state about to be entered (registered below).
    always_comb begin
        instr_ready_nx = (state_nx == S_IDLE);
        reg_write_nx   = 1'b0;
        mem_to_reg_nx  = 1'b0;
        mem_read_nx    = 1'b0;
        mem_write_nx   = 1'b0;
        alu_src_nx     = 2'b00;
        pc_src_nx      = 1'b0;
        pc_write_nx    = 1'b0;
        alu_ctrl_nx    = {ALU_CTRL_W{1'b0}};
        custom_en_nx   = 1'b0;
        cop_start_nx   = 1'b0;
        trap_nx        = 1'b0;
        case (state_nx)
            S_EXEC: begin
                alu_ctrl_nx = ALU_CTRL_W'(code_s);
                if ((cls_s == C_LOAD) || (cls_s == C_STORE)) begin
                    alu_src_nx = 2'b10;
                end else if (cls_s == C_BRANCH) begin
                    pc_src_nx   = 1'b1;
                    pc_write_nx = 1'b1;
                end else begin
                    alu_src_nx = 2'b00;
                end
            end
            S_MEM: begin
                alu_ctrl_nx  = ALU_CTRL_W'(code_s);
                alu_src_nx   = 2'b10;
                mem_read_nx  = (cls_s == C_LOAD);
                mem_write_nx = (cls_s == C_STORE);
            end
            S_COP_WAIT: begin
                alu_ctrl_nx  = ALU_CTRL_W'(code_s);
                custom_en_nx = 1'b1;
                cop_start_nx = (state_r != S_COP_WAIT);
            end
            S_WB: begin
                alu_ctrl_nx   = ALU_CTRL_W'(code_s);
                reg_write_nx  = 1'b1;
                mem_to_reg_nx = (cls_s == C_LOAD);
                pc_write_nx   = 1'b1;
            end
            S_TRAP: trap_nx = 1'b1;
            S_IDLE: begin
                // The only MEM -> IDLE path is a completed store: retire it.
                pc_write_nx = (state_r == S_MEM);
            end
            default: trap_nx = 1'b0;
        endcase
    end

    // State, latched instruction fields, wait counter and trap cause.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= S_IDLE;
            op_r         <= 7'd0;
            f3_r         <= 3'd0;
            f7_5_r       <= 1'b0;
            cop_cnt_r    <= {CNT_W{1'b0}};
            trap_cause_r <= CAUSE_NONE;
            cop_op_r     <= 3'd0;
        end else begin
            state_r      <= state_nx;
            trap_cause_r <= trap_cause_nx;
            if (accept_s) begin
                op_r   <= opcode;
                f3_r   <= funct3;
                f7_5_r <= funct7[5];
            end
            if ((state_r == S_DECODE) && (state_nx == S_COP_WAIT)) begin
                cop_op_r <= f3_r;
            end
            if (state_nx != S_COP_WAIT) begin
                cop_cnt_r <= {CNT_W{1'b0}};
            end else if (state_r != S_COP_WAIT) begin
                cop_cnt_r <= CNT_W'(1);
            end else begin
                cop_cnt_r <= cop_cnt_r + CNT_W'(1);
            end
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_ready_r <= 1'b1;
            reg_write_r   <= 1'b0;
            mem_to_reg_r  <= 1'b0;
            mem_read_r    <= 1'b0;
            mem_write_r   <= 1'b0;
            alu_src_r     <= 2'b00;
            pc_src_r      <= 1'b0;
            pc_write_r    <= 1'b0;
            alu_ctrl_r    <= {ALU_CTRL_W{1'b0}};
            custom_en_r   <= 1'b0;
            cop_start_r   <= 1'b0;
            trap_r        <= 1'b0;
        end else begin
            instr_ready_r <= instr_ready_nx;
            reg_write_r   <= reg_write_nx;
            mem_to_reg_r  <= mem_to_reg_nx;
            mem_read_r    <= mem_read_nx;
            mem_write_r   <= mem_write_nx;
            alu_src_r     <= alu_src_nx;
            pc_src_r      <= pc_src_nx;
            pc_write_r    <= pc_write_nx;
            alu_ctrl_r    <= alu_ctrl_nx;
            custom_en_r   <= custom_en_nx;
            cop_start_r   <= cop_start_nx;
            trap_r        <= trap_nx;
        end
    end

    assign instr_ready = instr_ready_r;
    assign reg_write   = reg_write_r;
    assign mem_to_reg  = mem_to_reg_r;
    assign mem_read    = mem_read_r;
    assign mem_write   = mem_write_r;
    assign alu_src     = alu_src_r;
    assign pc_src      = pc_src_r;
    assign pc_write    = pc_write_r;
    assign alu_ctrl    = alu_ctrl_r;
    assign custom_en   = custom_en_r;
    assign cop_start   = cop_start_r;
    assign cop_op      = cop_op_r;
    assign trap        = trap_r;
    assign trap_cause  = trap_cause_r;

`ifdef CTRL_PERF_EN
    logic [PERF_W-1:0] perf_retired_r;
    logic [PERF_W-1:0] perf_stall_r;
    logic              stall_s;

    // A stall cycle is a MEM or COP_WAIT cycle that does not complete.
    always_comb begin
        stall_s = 1'b0;
        if (state_r == S_MEM) begin
            stall_s = !mem_ready;
        end else if (state_r == S_COP_WAIT) begin
            stall_s = !cop_done;
        end else begin
            stall_s = 1'b0;
        end
    end

    // Saturating counters; retire counts on the same edge that raises pc_write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_retired_r <= {PERF_W{1'b0}};
            perf_stall_r   <= {PERF_W{1'b0}};
        end else begin
            if (pc_write_nx && (perf_retired_r != {PERF_W{1'b1}})) begin
                perf_retired_r <= perf_retired_r + PERF_W'(1);
            end
            if (stall_s && (perf_stall_r != {PERF_W{1'b1}})) begin
                perf_stall_r <= perf_stall_r + PERF_W'(1);
            end
        end
    end

    assign perf_retired = perf_retired_r;
    assign perf_stall   = perf_stall_r;
`else
    assign perf_retired = {PERF_W{1'b0}};
    assign perf_stall   = {PERF_W{1'b0}};
`endif

endmodule

// File: tb/tb_ctrl_mc.sv
// ---------------------------------------------------------------------------
// tb_ctrl_mc -- self-checking bench for ctrl_mc.
// For every instruction the bench builds the expected cycle-by-cycle output
// trace from the instruction rules (classification tables, memory/coprocessor
// wait counts, timeout limit), drives the matching handshake inputs and
// compares the DUT outputs each cycle on the falling edge.
// ---------------------------------------------------------------------------
module tb_ctrl_mc;

    localparam int TO   = 12;
    localparam int NCOP = 2;
    localparam int AW   = 4;
    localparam int PW   = 32;

    logic          clk, rst_n, instr_valid, instr_ready;
    logic [6:0]    opcode, funct7;
    logic [2:0]    funct3, cop_op;
    logic          mem_ready, cop_done, trap_clr;
    logic          reg_write, mem_to_reg, mem_read, mem_write, pc_src, pc_write;
    logic [1:0]    alu_src, trap_cause;
    logic [AW-1:0] alu_ctrl;
    logic          custom_en, cop_start, trap;
    logic [PW-1:0] perf_retired, perf_stall;

    ctrl_mc #(.ALU_CTRL_W(AW), .NUM_COP_OPS(NCOP), .COP_TIMEOUT(TO), .PERF_W(PW)) dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .opcode(opcode), .funct3(funct3), .funct7(funct7), .mem_ready(mem_ready),
        .cop_done(cop_done), .trap_clr(trap_clr), .reg_write(reg_write),
        .mem_to_reg(mem_to_reg), .mem_read(mem_read), .mem_write(mem_write),
        .alu_src(alu_src), .pc_src(pc_src), .pc_write(pc_write), .alu_ctrl(alu_ctrl),
        .custom_en(custom_en), .cop_start(cop_start), .cop_op(cop_op), .trap(trap),
        .trap_cause(trap_cause), .perf_retired(perf_retired), .perf_stall(perf_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       instr_ready, reg_write, mem_to_reg, mem_read, mem_write;
        logic [1:0] alu_src;
        logic       pc_src, pc_write;
        logic [3:0] alu_ctrl;
        logic       custom_en, cop_start;
        logic [2:0] cop_op;
        logic       trap;
        logic [1:0] trap_cause;
    } out_t;

    typedef struct packed {
        out_t o;
        logic mem_ready, cop_done, trap_clr;
    } step_t;

    step_t      trace[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         m_retired = 0;
    int         m_stall = 0;
    logic [2:0] m_cop_op = 3'd0;

    // Legal R-type and branch funct3 -> ALU code; -1 marks an illegal funct3.
    int r_alu[8]  = '{0, 9, -1, -1, 8, 10, 3, 2};
    int br_alu[8] = '{4, 5, -1, -1, 11, 12, -1, -1};

    function automatic out_t sample();
        out_t s;
        s.instr_ready = instr_ready; s.reg_write = reg_write; s.mem_to_reg = mem_to_reg;
        s.mem_read = mem_read; s.mem_write = mem_write; s.alu_src = alu_src;
        s.pc_src = pc_src; s.pc_write = pc_write; s.alu_ctrl = alu_ctrl[3:0];
        s.custom_en = custom_en; s.cop_start = cop_start; s.cop_op = cop_op;
        s.trap = trap; s.trap_cause = trap_cause;
        return s;
    endfunction

    function automatic step_t base(input int code);
        step_t s;
        s = '0;
        s.o.cop_op   = m_cop_op;
        s.o.alu_ctrl = 4'(code);
        return s;
    endfunction

    // Expected trace of one instruction, from DECODE to the first IDLE cycle.
    // w: cycles mem_ready stays low; d: COP_WAIT cycle carrying cop_done (0 = never);
    // th: cycles spent in TRAP (trap_clr on the last one).
    task automatic build(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input int w, input int d, input int th);
        step_t s;
        int kind, code, n;
        logic [1:0] cause;
        trace.delete();
        s = base(0);
        s.trap_clr = 1'($urandom_range(0, 1));   // stray clear outside TRAP
        trace.push_back(s);
        code = 0; cause = 2'b00;
        if (op == 7'b0110011 && r_alu[f3] >= 0) begin
            kind = 0; code = (f3 == 3'd0 && f7[5]) ? 1 : r_alu[f3];
        end else if (op == 7'b0000011) kind = 1;
        else if (op == 7'b0100011) kind = 2;
        else if (op == 7'b1100011 && br_alu[f3] >= 0) begin
            kind = 3; code = br_alu[f3];
        end else if (op == 7'b0001011 && int'(f3) < NCOP) begin
            kind = 4; code = (f3 == 3'd0) ? 6 : ((f3 == 3'd1) ? 7 : 13);
        end else kind = 5;
        case (kind)
            0: begin
                trace.push_back(base(code));
                s = base(code); s.o.reg_write = 1'b1; s.o.pc_write = 1'b1; trace.push_back(s);
                m_retired++;
            end
            1, 2: begin
                s = base(0); s.o.alu_src = 2'b10; trace.push_back(s);
                for (int i = 0; i <= w; i++) begin
                    s = base(0); s.o.alu_src = 2'b10;
                    if (kind == 1) s.o.mem_read = 1'b1; else s.o.mem_write = 1'b1;
                    s.mem_ready = (i == w);
                    if (i < w) m_stall++;
                    trace.push_back(s);
                end
                if (kind == 1) begin
                    s = base(0); s.o.reg_write = 1'b1; s.o.mem_to_reg = 1'b1; s.o.pc_write = 1'b1;
                    trace.push_back(s);
                end
                m_retired++;
            end
            3: begin
                s = base(code); s.o.pc_src = 1'b1; s.o.pc_write = 1'b1; trace.push_back(s);
                m_retired++;
            end
            4: begin
                m_cop_op = f3;
                n = (d >= 1 && d <= TO) ? d : TO;
                for (int i = 1; i <= n; i++) begin
                    s = base(code); s.o.custom_en = 1'b1; s.o.cop_start = (i == 1);
                    s.cop_done = (i == d);
                    if (i != d) m_stall++;
                    trace.push_back(s);
                end
                if (d >= 1 && d <= TO) begin
                    s = base(code); s.o.reg_write = 1'b1; s.o.pc_write = 1'b1; trace.push_back(s);
                    m_retired++;
                end else cause = 2'b10;
            end
            default: cause = 2'b01;
        endcase
        if (cause != 2'b00) begin
            for (int i = 1; i <= th; i++) begin
                s = base(0); s.o.trap = 1'b1; s.o.trap_cause = cause; s.trap_clr = (i == th);
                trace.push_back(s);
            end
        end
        s = base(0); s.o.instr_ready = 1'b1; s.o.pc_write = (kind == 2);
        trace.push_back(s);
    endtask

    // Present an instruction in the current IDLE cycle, then follow the trace.
    task automatic issue(input string name, input logic [6:0] op, input logic [2:0] f3,
                         input logic [6:0] f7, input int w, input int d, input int th);
        out_t got;
        build(op, f3, f7, w, d, th);
        instr_valid = 1'b1; opcode = op; funct3 = f3; funct7 = f7;
        for (int k = 0; k < trace.size(); k++) begin
            @(negedge clk);
            if (k == 0) begin
                instr_valid = 1'b0;
                opcode = 7'($urandom); funct3 = 3'($urandom); funct7 = 7'($urandom);
            end
            got = sample();
            n_cmp++;
            if (got !== trace[k].o) begin
                n_bad++;
                $display("FAIL %s step %0d: got %h expected %h", name, k, got, trace[k].o);
            end
            mem_ready = trace[k].mem_ready;
            cop_done  = trace[k].cop_done;
            trap_clr  = trace[k].trap_clr;
        end
        n_cmp++;
`ifdef CTRL_PERF_EN
        if (perf_retired !== PW'(m_retired) || perf_stall !== PW'(m_stall)) begin
            n_bad++;
            $display("FAIL %s perf: got %0d/%0d expected %0d/%0d", name, perf_retired, perf_stall, m_retired, m_stall);
        end
`else
        if (perf_retired !== '0 || perf_stall !== '0) begin
            n_bad++;
            $display("FAIL %s perf: got %0d/%0d expected 0/0", name, perf_retired, perf_stall);
        end
`endif
    endtask

    task automatic test_reset();
        out_t exp;
        exp = '0; exp.instr_ready = 1'b1;
        rst_n = 1'b0; instr_valid = 1'b0; opcode = 7'd0; funct3 = 3'd0; funct7 = 7'd0;
        mem_ready = 1'b0; cop_done = 1'b0; trap_clr = 1'b0;
        #12;
        n_cmp++;
        if (sample() !== exp || perf_retired !== '0 || perf_stall !== '0) begin
            n_bad++;
            $display("FAIL reset: got %h expected %h", sample(), exp);
        end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_r_type();
        issue("add", 7'b0110011, 3'd0, 7'h00, 0, 0, 1);
        issue("sub", 7'b0110011, 3'd0, 7'h20, 0, 0, 1);
        issue("and", 7'b0110011, 3'd7, 7'h00, 0, 0, 1);
        issue("or",  7'b0110011, 3'd6, 7'h00, 0, 0, 1);
        issue("xor", 7'b0110011, 3'd4, 7'h00, 0, 0, 1);
        issue("sll", 7'b0110011, 3'd1, 7'h00, 0, 0, 1);
        issue("srl", 7'b0110011, 3'd5, 7'h20, 0, 0, 1);
    endtask

    task automatic test_load_store();
        issue("lw_wait3", 7'b0000011, 3'd2, 7'h00, 3, 0, 1);
        issue("lw_wait0", 7'b0000011, 3'd2, 7'h00, 0, 0, 1);
        issue("sw_wait2", 7'b0100011, 3'd2, 7'h00, 2, 0, 1);
        issue("sw_wait0", 7'b0100011, 3'd2, 7'h00, 0, 0, 1);
    endtask

    task automatic test_branch();
        issue("beq", 7'b1100011, 3'd0, 7'h00, 0, 0, 1);
        issue("bne", 7'b1100011, 3'd1, 7'h00, 0, 0, 1);
        issue("blt", 7'b1100011, 3'd4, 7'h00, 0, 0, 1);
        issue("bge", 7'b1100011, 3'd5, 7'h00, 0, 0, 1);
    endtask

    task automatic test_custom();
        issue("relu_done10", 7'b0001011, 3'd1, 7'h00, 0, 10, 1);
        issue("matmul_done1", 7'b0001011, 3'd0, 7'h00, 0, 1, 1);
        issue("cop_done_at_limit", 7'b0001011, 3'd1, 7'h00, 0, TO, 1);
    endtask

    task automatic test_timeout();
        issue("cop_timeout", 7'b0001011, 3'd0, 7'h00, 0, 0, 3);
        issue("cop_late_done", 7'b0001011, 3'd1, 7'h00, 0, TO + 1, 1);
    endtask

    task automatic test_illegal();
        issue("opcode_7f", 7'b1111111, 3'd0, 7'h00, 0, 0, 2);
        issue("custom_f3_2", 7'b0001011, 3'd2, 7'h00, 0, 0, 1);
        issue("r_f3_2", 7'b0110011, 3'd2, 7'h00, 0, 0, 1);
        issue("branch_f3_2", 7'b1100011, 3'd2, 7'h00, 0, 0, 2);
    endtask

    task automatic test_back_to_back();
        logic [6:0] ops[6];
        logic [6:0] op;
        ops = '{7'b0110011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b0001011, 7'b0110011};
        for (int i = 0; i < 150; i++) begin
            op = ops[$urandom_range(0, 5)];
            if ($urandom_range(0, 7) == 0) op = 7'($urandom);
            issue("random", op, 3'($urandom), ($urandom_range(0, 1) == 1) ? 7'h20 : 7'($urandom),
                  $urandom_range(0, 4), $urandom_range(0, TO + 2), $urandom_range(1, 3));
        end
    endtask

    task automatic test_reset_mid_op();
        out_t exp;
        instr_valid = 1'b1; opcode = 7'b0100011; funct3 = 3'd2; funct7 = 7'h00;
        @(negedge clk); instr_valid = 1'b0;   // DECODE
        @(negedge clk);                        // EXEC
        @(negedge clk);                        // MEM, memory not ready
        n_cmp++;
        if (mem_write !== 1'b1) begin
            n_bad++; $display("FAIL rst_mid_mem_write_before: got %b expected 1", mem_write);
        end
        #1 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (mem_write !== 1'b0 || pc_write !== 1'b0 || instr_ready !== 1'b1 ||
            perf_retired !== '0 || perf_stall !== '0) begin
            n_bad++;
            $display("FAIL rst_mid_abort: got mw=%b pw=%b rdy=%b ret=%0d stall=%0d expected 0 0 1 0 0",
                     mem_write, pc_write, instr_ready, perf_retired, perf_stall);
        end
        m_retired = 0; m_stall = 0; m_cop_op = 3'd0;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        exp = '0; exp.instr_ready = 1'b1;
        n_cmp++;
        if (sample() !== exp || perf_retired !== '0) begin
            n_bad++; $display("FAIL rst_mid_idle: got %h expected %h", sample(), exp);
        end
        issue("add_after_rst", 7'b0110011, 3'd0, 7'h00, 0, 0, 1);
    endtask

    initial begin
        test_reset();
        test_r_type();
        test_load_store();
        test_branch();
        test_custom();
        test_timeout();
        test_illegal();
        test_back_to_back();
        test_reset_mid_op();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
